quick_spi_master: RTL and testbench
===================================

// Module: quick_spi_master
// PURPOSE
//  Parameterised SPI master. Serialises an OUTGOING_DATA_WIDTH word onto mosi and,
//  for reads, captures INCOMING_DATA_WIDTH bits from miso afterwards.
//  Sits between a register/command controller and external SPI slaves (ADC, DAC, PLL).
//  Supports configurable byte order, bit order, CPOL/CPHA and one-hot slave select.
// PARAMETERS
//  INCOMING_DATA_WIDTH      8   bits received in a read (multiple of 8)
//  OUTGOING_DATA_WIDTH      16  bits sent in every transaction (multiple of 8)
//  CPOL                     0   sclk idle level
//  CPHA                     0   0: sample on leading edge, shift on trailing; 1: reverse
//  EXTRA_WRITE_SCLK_TOGGLES 6   idle sclk toggles after last written bit (even)
//  EXTRA_READ_SCLK_TOGGLES  4   dummy toggles between write and read phases (even)
//  BYTES_ORDER              0   0: little endian (byte [7:0] first); 1: big endian (MS byte first)
//  BITS_ORDER               1   0: MSB first within a byte; 1: LSB first
//  NUMBER_OF_SLAVES         2   width of slave / ss_n
// PORTS
//  clk                 in  1     system clock; all logic on rising edge
//  reset               in  1     synchronous, active-high reset
//  enable              in  1     block enable; 0 holds FSM in IDLE
//  start_transaction   in  1     level request; sampled in IDLE only
//  slave               in  NOS   one-hot slave mask, captured at start
//  operation           in  1     0 = write, 1 = read; captured at start
//  end_of_transaction  out 1     one-clk pulse when transaction completes
//  incoming_data       out IDW   last read result, held until next read completes
//  outgoing_data       in  ODW   word to send, captured at start
//  mosi                out 1     serial data out
//  miso                in  1     serial data in
//  sclk                out 1     SPI clock = clk/2 while active
//  ss_n                out NOS   active-low selects
// BEHAVIOUR
//  Reset: FSM=IDLE, sclk=CPOL, mosi=0, ss_n=all 1, end_of_transaction=0, incoming_data=0.
//  Reset mid-transaction aborts at once; no end_of_transaction pulse.
//  FSM: IDLE -> WRITE -> (op=0) WRITE_TAIL -> DONE -> IDLE
//                      -> (op=1) READ_GAP -> READ -> DONE -> IDLE
//  IDLE: enable & start_transaction -> capture outgoing_data/slave/operation, reorder data
//   into transmit order (BYTES_ORDER, BITS_ORDER), go WRITE. Next clk ss_n=~slave,
//   mosi=first bit, sclk=CPOL.
//  Active states: sclk toggles every clk; bit counter counts toggles.
//   CPHA=0: mosi updates on trailing edge, miso sampled on leading edge; CPHA=1 swapped.
//  WRITE: 2*ODW toggles. WRITE_TAIL: EXTRA_WRITE_SCLK_TOGGLES toggles, mosi=0.
//  READ_GAP: EXTRA_READ_SCLK_TOGGLES toggles, mosi=0, miso ignored.
//  READ: 2*IDW toggles; miso shifted into buffer; at end, buffer reordered per
//   BYTES_ORDER/BITS_ORDER into incoming_data.
//  DONE: one clk; ss_n=all 1, sclk=CPOL, end_of_transaction=1. Then IDLE.
//  start held high -> next transaction begins the clk after returning to IDLE.
//  enable dropped mid-transaction: transaction completes; new starts blocked.
//  Inputs changing mid-transaction: ignored (captured copies used).
//  Write transaction leaves incoming_data unchanged.
//  slave=0: transaction runs with no ss_n asserted.
// STRUCTURE
//  Shared package: FSM state enum, BYTE_ORDER_LE/BE and BIT_ORDER_MSB/LSB constants.
//  One sub-module natural: quick_spi_reorder (combinational byte/bit reordering,
//  used for tx and rx paths).
// TESTING
//  BYTES_ORDER=1, BITS_ORDER=1, write 16'hCC81, slave=2'b01 -> ss_n=2'b10;
//   mosi on successive leading edges 0,0,1,1,0,0,1,1, 1,0,0,0,0,0,0,1;
//   end_of_transaction after 32+6 toggles.
//  Same config, read, miso drives 8'hA5 LSB first after 32+4 toggles
//   -> incoming_data=8'hA5 at end_of_transaction.
//  BYTES_ORDER=0, BITS_ORDER=0, write 16'hCC81 -> mosi 8'h81 MSB first,
//   then 8'hCC MSB first.
//  start_transaction held high, operation toggled on each end_of_transaction
//   -> back-to-back write/read; one idle clk between them, ss_n high during it.
//  enable=0 with start=1 -> ss_n=2'b11, sclk=CPOL, no pulse ever.
//  reset asserted at toggle 10 -> next clk all outputs at reset values, FSM IDLE.

Source files
------------

// File: rtl/quick_spi_master_pkg.sv
// Shared types and ordering constants for the quick SPI master and its reorder helper.
package quick_spi_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_WRITE_TAIL,
    ST_READ_GAP,
    ST_READ,
    ST_DONE
  } spi_state_e;

  localparam int BYTE_ORDER_LE = 0;
  localparam int BYTE_ORDER_BE = 1;
  localparam int BIT_ORDER_MSB = 0;
  localparam int BIT_ORDER_LSB = 1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/quick_spi_reorder.sv
// Maps a data word to wire order (bit [WIDTH-1] travels first) or back again;
// the mapping is its own inverse, so one block serves both tx and rx.
module quick_spi_reorder
  import quick_spi_master_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int BYTES_ORDER = BYTE_ORDER_LE,
  parameter int BITS_ORDER  = BIT_ORDER_LSB
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);
  localparam int NB = WIDTH / 8;

  for (genvar k = 0; k < NB; k++) begin : g_byte
    // Wire slot k (k = 0 sent first) lives in the top byte of data_o.
    localparam int SRC = (BYTES_ORDER == BYTE_ORDER_LE) ? k : NB - 1 - k;
    for (genvar b = 0; b < 8; b++) begin : g_bit
      localparam int SB = (BITS_ORDER == BIT_ORDER_LSB) ? 7 - b : b;
      assign data_o[(NB - 1 - k) * 8 + b] = data_i[SRC * 8 + SB];
    end
  end

endmodule

// File: rtl/quick_spi_master.sv
// Parameterised SPI master: serialises a write word and optionally reads a reply word.
// sclk runs at clk/2; each clk in an active state is one sclk toggle.
module quick_spi_master
  import quick_spi_master_pkg::*;
#(
  parameter int INCOMING_DATA_WIDTH      = 8,
  parameter int OUTGOING_DATA_WIDTH      = 16,
  parameter int CPOL                     = 0,
  parameter int CPHA                     = 0,
  parameter int EXTRA_WRITE_SCLK_TOGGLES = 6,
  parameter int EXTRA_READ_SCLK_TOGGLES  = 4,
  parameter int BYTES_ORDER              = BYTE_ORDER_LE,
  parameter int BITS_ORDER               = BIT_ORDER_LSB,
  parameter int NUMBER_OF_SLAVES         = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           start_transaction,
  input  logic [NUMBER_OF_SLAVES-1:0]    slave,
  input  logic                           operation,
  output logic                           end_of_transaction,
  output logic [INCOMING_DATA_WIDTH-1:0] incoming_data,
  input  logic [OUTGOING_DATA_WIDTH-1:0] outgoing_data,
  output logic                           mosi,
  input  logic                           miso,
  output logic                           sclk,
  output logic [NUMBER_OF_SLAVES-1:0]    ss_n
);
  localparam int IDW     = INCOMING_DATA_WIDTH;
  localparam int ODW     = OUTGOING_DATA_WIDTH;
  localparam int MAX_TGL = max_int(max_int(2 * ODW, 2 * IDW),
                                   max_int(EXTRA_WRITE_SCLK_TOGGLES, EXTRA_READ_SCLK_TOGGLES));
  localparam int CNT_W   = $clog2(MAX_TGL + 1);

  localparam logic [CNT_W-1:0] WR_TGL = CNT_W'(2 * ODW);
  localparam logic [CNT_W-1:0] RD_TGL = CNT_W'(2 * IDW);
  localparam logic [CNT_W-1:0] WT_TGL = CNT_W'(EXTRA_WRITE_SCLK_TOGGLES);
  localparam logic [CNT_W-1:0] RG_TGL = CNT_W'(EXTRA_READ_SCLK_TOGGLES);
  localparam logic IDLE_SCLK      = (CPOL != 0);
  localparam logic SAMPLE_ON_LEAD = (CPHA == 0);

  spi_state_e                  state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d, tgl;
  logic [ODW-1:0]              tx_q, tx_d, tx_order;
  logic [IDW-1:0]              rx_q, rx_d, rx_shift, rx_src, rx_order, inc_q, inc_d;
  logic [NUMBER_OF_SLAVES-1:0] ss_n_q, ss_n_d;
  logic op_q, op_d, sclk_q, sclk_d, mosi_q, mosi_d, eot_q, eot_d;
  logic leading, shift_now, sample_now, finish;

  quick_spi_reorder #(
    .WIDTH      (ODW),
    .BYTES_ORDER(BYTES_ORDER),
    .BITS_ORDER (BITS_ORDER)
  ) u_tx_reorder (
    .data_i(outgoing_data),
    .data_o(tx_order)
  );

  quick_spi_reorder #(
    .WIDTH      (IDW),
    .BYTES_ORDER(BYTES_ORDER),
    .BITS_ORDER (BITS_ORDER)
  ) u_rx_reorder (
    .data_i(rx_src),
    .data_o(rx_order)
  );

  // tgl is the 1-based number of the toggle produced at the coming edge; odd = leading.
  assign tgl        = cnt_q + CNT_W'(1);
  assign leading    = tgl[0];
  assign shift_now  = SAMPLE_ON_LEAD ? !leading : (leading && (tgl != CNT_W'(1)));
  assign sample_now = (leading == SAMPLE_ON_LEAD);
  assign rx_shift   = {rx_q[IDW-2:0], miso};
  // With CPHA=1 the final sample lands on the closing edge itself.
  assign rx_src     = SAMPLE_ON_LEAD ? rx_q : rx_shift;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    op_d    = op_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    ss_n_d  = ss_n_q;
    eot_d   = 1'b0;
    inc_d   = inc_q;
    finish  = 1'b0;

    if (state_q != ST_IDLE && state_q != ST_DONE) begin
      sclk_d = ~sclk_q;
      cnt_d  = tgl;
    end

    case (state_q)
      ST_IDLE: begin
        sclk_d = IDLE_SCLK;
        mosi_d = 1'b0;
        ss_n_d = '1;
        cnt_d  = '0;
        if (enable && start_transaction) begin
          state_d = ST_WRITE;
          tx_d    = tx_order << 1;
          mosi_d  = tx_order[ODW-1];
          ss_n_d  = ~slave;
          op_d    = operation;
        end
      end
      ST_WRITE: begin
        if (shift_now) begin
          mosi_d = tx_q[ODW-1];
          tx_d   = tx_q << 1;
        end
        if (tgl == WR_TGL) begin
          cnt_d  = '0;
          mosi_d = 1'b0;
          if (op_q)                state_d = (RG_TGL == '0) ? ST_READ : ST_READ_GAP;
          else if (WT_TGL == '0)   finish  = 1'b1;
          else                     state_d = ST_WRITE_TAIL;
        end
      end
      ST_WRITE_TAIL: begin
        if (tgl == WT_TGL) finish = 1'b1;
      end
      ST_READ_GAP: begin
        if (tgl == RG_TGL) begin
          cnt_d   = '0;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        if (sample_now) rx_d = rx_shift;
        if (tgl == RD_TGL) begin
          inc_d  = rx_order;
          finish = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        sclk_d  = IDLE_SCLK;
        ss_n_d  = '1;
        mosi_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase

    if (finish) begin
      state_d = ST_DONE;
      cnt_d   = '0;
      ss_n_d  = '1;
      mosi_d  = 1'b0;
      eot_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sclk_q  <= IDLE_SCLK;
      mosi_q  <= 1'b0;
      ss_n_q  <= '1;
      eot_q   <= 1'b0;
      inc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      ss_n_q  <= ss_n_d;
      eot_q   <= eot_d;
      inc_q   <= inc_d;
    end
  end

  // Shift registers and the captured opcode are only meaningful once loaded.
  always_ff @(posedge clk) begin
    tx_q <= tx_d;
    rx_q <= rx_d;
    op_q <= op_d;
  end

  assign end_of_transaction = eot_q;
  assign incoming_data      = inc_q;
  assign mosi               = mosi_q;
  assign sclk               = sclk_q;
  assign ss_n               = ss_n_q;

endmodule

// File: tb/tb_quick_spi_master.sv
// Bench for quick_spi_master: a big-endian/LSB-first instance drives the checks, a
// little-endian/MSB-first twin shares the stimulus to cover the other ordering.
module tb_quick_spi_master;
  localparam int IDW = 8;
  localparam int ODW = 16;
  localparam int NOS = 2;

  logic           clk = 1'b0;
  logic           reset, enable, start, operation, miso;
  logic [NOS-1:0] slave;
  logic [ODW-1:0] outgoing;
  logic           eot_a, eot_b, mosi_a, mosi_b, sclk_a, sclk_b;
  logic [IDW-1:0] inc_a, inc_b;
  logic [NOS-1:0] ss_a, ss_b;

  always #5 clk = ~clk;

  quick_spi_master #(
    .INCOMING_DATA_WIDTH(IDW), .OUTGOING_DATA_WIDTH(ODW), .CPOL(0), .CPHA(0),
    .EXTRA_WRITE_SCLK_TOGGLES(6), .EXTRA_READ_SCLK_TOGGLES(4),
    .BYTES_ORDER(1), .BITS_ORDER(1), .NUMBER_OF_SLAVES(NOS)
  ) u_dut_a (
    .clk(clk), .reset(reset), .enable(enable), .start_transaction(start),
    .slave(slave), .operation(operation), .end_of_transaction(eot_a),
    .incoming_data(inc_a), .outgoing_data(outgoing), .mosi(mosi_a),
    .miso(miso), .sclk(sclk_a), .ss_n(ss_a)
  );

  quick_spi_master #(
    .INCOMING_DATA_WIDTH(IDW), .OUTGOING_DATA_WIDTH(ODW), .CPOL(0), .CPHA(0),
    .EXTRA_WRITE_SCLK_TOGGLES(6), .EXTRA_READ_SCLK_TOGGLES(4),
    .BYTES_ORDER(0), .BITS_ORDER(0), .NUMBER_OF_SLAVES(NOS)
  ) u_dut_b (
    .clk(clk), .reset(reset), .enable(enable), .start_transaction(start),
    .slave(slave), .operation(operation), .end_of_transaction(eot_b),
    .incoming_data(inc_b), .outgoing_data(outgoing), .mosi(mosi_b),
    .miso(miso), .sclk(sclk_b), .ss_n(ss_b)
  );

  // Bit i of the wire stream for a value of nbytes bytes under the given ordering.
  function automatic logic wire_bit(input logic [15:0] v, input int nbytes,
                                    input int big_end, input int lsb_first, input int i);
    int p, byte_idx, bit_idx;
    p        = i / 8;
    byte_idx = (big_end != 0) ? nbytes - 1 - p : p;
    bit_idx  = (lsb_first != 0) ? i % 8 : 7 - i % 8;
    return v[byte_idx * 8 + bit_idx];
  endfunction

  // Slave model: records mosi on every leading (rising) sclk edge, counts toggles.
  int   lead_a = 0, lead_b = 0, tog_a = 0;
  logic mq_a[$];
  logic mq_b[$];
  always @(posedge sclk_a) begin mq_a.push_back(mosi_a); lead_a++; end
  always @(posedge sclk_b) begin mq_b.push_back(mosi_b); lead_b++; end
  always @(sclk_a) tog_a++;

  int             rd_base;
  logic           rd_en;
  logic [IDW-1:0] rd_val;
  always_comb begin
    miso = 1'b0;
    if (rd_en && lead_a >= rd_base && lead_a < rd_base + IDW)
      miso = wire_bit(16'(rd_val), 1, 1, 1, lead_a - rd_base);
  end

  int errors = 0, checks = 0;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wait_eot(output bit found);
    found = 1'b0;
    for (int c = 0; c < 400 && !found; c++) begin
      @(negedge clk);
      if (eot_a) found = 1'b1;
    end
  endtask

  logic [IDW-1:0] exp_inc_b;
  logic [ODW-1:0] last_got_a, last_got_b;

  task automatic run_txn(input logic op, input logic [ODW-1:0] data, input logic [NOS-1:0] slv,
                         input logic [IDW-1:0] rdv, input logic [NOS-1:0] exp_ss,
                         input logic [IDW-1:0] exp_inc);
    int bq_a, bq_b, bl, bt, exp_leads;
    bit found;
    logic [ODW-1:0] got_a, got_b, exp_a, exp_b;
    logic extra;
    for (int i = 0; i < ODW; i++) begin
      exp_a[i] = wire_bit(data, 2, 1, 1, i);
      exp_b[i] = wire_bit(data, 2, 0, 0, i);
    end
    exp_leads = op ? ODW + 2 + IDW : ODW + 3;
    @(negedge clk);
    operation = op; outgoing = data; slave = slv; rd_val = rdv; rd_en = op;
    bq_a = mq_a.size(); bq_b = mq_b.size(); bl = lead_a; bt = tog_a;
    rd_base = lead_a + ODW + 2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    outgoing = ~data; slave = ~slv; operation = ~op;
    chk("ss_n_active", 32'(ss_a), 32'(exp_ss));
    chk("sclk_first", 32'(sclk_a), 32'd0);
    chk("mosi_first", 32'(mosi_a), 32'(exp_a[0]));
    wait_eot(found);
    chk("eot_seen", 32'(found), 32'd1);
    chk("eot_b_sync", 32'(eot_b), 32'd1);
    chk("toggles", 32'(tog_a - bt), op ? 32'(2 * ODW + 4 + 2 * IDW) : 32'(2 * ODW + 6));
    chk("leads", 32'(lead_a - bl), 32'(exp_leads));
    got_a = '0; got_b = '0; extra = 1'b0;
    for (int i = 0; i < exp_leads; i++) begin
      if (bq_a + i < mq_a.size()) begin
        if (i < ODW) got_a[i] = mq_a[bq_a + i];
        else         extra = extra | mq_a[bq_a + i];
      end
      if (i < ODW && bq_b + i < mq_b.size()) got_b[i] = mq_b[bq_b + i];
    end
    last_got_a = got_a; last_got_b = got_b;
    chk("mosi_seq_a", 32'(got_a), 32'(exp_a));
    chk("mosi_seq_b", 32'(got_b), 32'(exp_b));
    chk("mosi_tail_zero", 32'(extra), 32'd0);
    chk("done_ss_sclk", 32'({ss_a, sclk_a}), 32'({2'b11, 1'b0}));
    if (op) for (int j = 0; j < IDW; j++) exp_inc_b[IDW - 1 - j] = rdv[j];
    chk("incoming_a", 32'(inc_a), 32'(exp_inc));
    chk("incoming_b", 32'(inc_b), 32'(exp_inc_b));
    @(negedge clk);
    chk("eot_one_clk", 32'({eot_a, ss_a}), 32'({1'b0, 2'b11}));
    rd_en = 1'b0;
  endtask

  typedef struct {
    logic           op;
    logic [ODW-1:0] data;
    logic [NOS-1:0] slv;
    logic [IDW-1:0] rdv;
    logic [NOS-1:0] exp_ss;
    logic [IDW-1:0] exp_inc;
  } vec_t;

  vec_t vecs[4];
  logic [NOS-1:0] sel[3];

  initial begin
    bit found, bad;
    int bt;
    logic op;
    logic [NOS-1:0] slv;
    logic [IDW-1:0] rdv, model_inc;

    vecs[0] = '{1'b0, 16'hCC81, 2'b01, 8'h00, 2'b10, 8'h00};
    vecs[1] = '{1'b1, 16'hCC81, 2'b01, 8'hA5, 2'b10, 8'hA5};
    vecs[2] = '{1'b0, 16'h1234, 2'b10, 8'h00, 2'b01, 8'hA5};
    vecs[3] = '{1'b1, 16'h00FF, 2'b00, 8'h3C, 2'b11, 8'h3C};
    sel[0] = 2'b00; sel[1] = 2'b01; sel[2] = 2'b10;

    reset = 1'b1; enable = 1'b0; start = 1'b0; operation = 1'b0; slave = '0;
    outgoing = '0; rd_en = 1'b0; rd_val = '0; rd_base = 0; exp_inc_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", 32'({sclk_a, mosi_a, ss_a, eot_a}), 32'({1'b0, 1'b0, 2'b11, 1'b0}));
    chk("rst_incoming", 32'(inc_a), 32'd0);
    reset = 1'b0; enable = 1'b1;
    @(negedge clk);
    chk("idle_ss", 32'(ss_a), 32'(2'b11));

    for (int i = 0; i < 4; i++) begin
      run_txn(vecs[i].op, vecs[i].data, vecs[i].slv, vecs[i].rdv, vecs[i].exp_ss, vecs[i].exp_inc);
      if (i == 0) begin
        chk("cc81_wire_be_lsb", 32'(last_got_a), 32'h81CC);
        chk("cc81_wire_le_msb", 32'(last_got_b), 32'h3381);
      end
    end

    model_inc = 8'h3C;
    for (int i = 0; i < 6; i++) begin
      op  = 1'($urandom_range(0, 1));
      slv = sel[$urandom_range(0, 2)];
      rdv = 8'($urandom);
      if (op) model_inc = rdv;
      run_txn(op, 16'($urandom), slv, rdv, ~slv, model_inc);
    end

    // Back-to-back: write then read with start held high.
    @(negedge clk);
    operation = 1'b0; slave = 2'b01; outgoing = 16'hCC81; start = 1'b1;
    wait_eot(found);
    chk("b2b_first_eot", 32'(found), 32'd1);
    operation = 1'b1; rd_val = 8'h5A; rd_en = 1'b1; rd_base = lead_a + ODW + 2;
    @(negedge clk);
    chk("b2b_idle_gap", 32'({eot_a, ss_a}), 32'({1'b0, 2'b11}));
    @(negedge clk);
    chk("b2b_second_start", 32'(ss_a), 32'(2'b10));
    start = 1'b0;
    wait_eot(found);
    chk("b2b_second_eot", 32'(found), 32'd1);
    chk("b2b_read_data", 32'(inc_a), 32'h5A);
    @(negedge clk);
    rd_en = 1'b0;

    // Enable dropped mid-transaction: completes, then no restart while start stays high.
    operation = 1'b0; slave = 2'b01; outgoing = 16'h0F0F; start = 1'b1;
    repeat (4) @(negedge clk);
    enable = 1'b0;
    wait_eot(found);
    chk("en_drop_completes", 32'(found), 32'd1);
    bad = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (eot_a || ss_a != 2'b11 || sclk_a) bad = 1'b1;
    end
    chk("en_blocked", 32'(bad), 32'd0);
    start = 1'b0; enable = 1'b1;

    // Reset at toggle 10 of a read.
    @(negedge clk);
    bt = tog_a; operation = 1'b1; slave = 2'b10; outgoing = 16'hFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (tog_a - bt >= 10) found = 1'b1;
      else @(negedge clk);
    end
    chk("rst_reach_tog10", 32'(tog_a - bt), 32'd10);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_outputs", 32'({sclk_a, mosi_a, ss_a, eot_a}), 32'({1'b0, 1'b0, 2'b11, 1'b0}));
    chk("rst_mid_incoming", 32'(inc_a), 32'd0);
    reset = 1'b0; exp_inc_b = '0;
    bad = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (eot_a || ss_a != 2'b11) bad = 1'b1;
    end
    chk("rst_no_pulse", 32'(bad), 32'd0);
    run_txn(1'b0, 16'hBEEF, 2'b01, 8'h00, 2'b10, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
